// File: rtl/spi_mem_writer.sv
// spi_mem_writer: SPI mode-0 WRITE (0x02) initiator for the external serial SRAM, clk/2 bit rate.
//   Optional macro SPI_WREN_EN: precede every frame with an 8-bit WREN (0x06) frame and a one-bit-period deselect.
//   Ports:
//     clk, rst_n                     clock, synchronous active-low reset
//     target_address[23:0]           byte address of the first byte written
//     write_value[31:0]              store data, sent little-endian (byte 0 = [7:0] first)
//     write_size[1:0]                0=byte, 1=halfword, 2/3=word
//     start_write                    request, sampled only while idle
//     write_done                     one-cycle pulse once the frame is complete and cs is released
//     busy                           high from the cycle after accept through the write_done cycle
//     sclk, mosi, cs                 SPI pins (sclk idle low, MSB first, cs active low)
module spi_mem_writer #(
  parameter logic [7:0] CMD_WRITE = 8'h02
`ifdef SPI_WREN_EN
  , parameter logic [7:0] CMD_WREN = 8'h06
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] target_address,
  input  logic [31:0] write_value,
  input  logic [1:0]  write_size,
  input  logic        start_write,
  output logic        write_done,
  output logic        busy,
  output logic        sclk,
  output logic        mosi,
  output logic        cs
);
`ifdef SPI_WREN_EN
  typedef enum logic [2:0] {IDLE, SHIFT, DONE, WREN, GAP} state_t;
  localparam int SW = 72;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int SW = 64;
`endif
  state_t state_q, state_d;
  logic [SW-1:0] sr_q, sr_d;
  logic [6:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  logic cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d, busy_q, busy_d;
  logic [63:0] frame;
  logic [6:0] n_bits;
  logic shifting;
`ifdef SPI_WREN_EN
  logic [6:0] n_q, n_d;
`endif
  // Data bytes are laid out little-endian; bytes beyond the access size are simply never shifted out.
  assign frame  = {CMD_WRITE, target_address, write_value[7:0], write_value[15:8], write_value[23:16], write_value[31:24]};
  assign n_bits = write_size == 2'd0 ? 7'd40 : write_size == 2'd1 ? 7'd48 : 7'd64;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SPI_WREN_EN
      n_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SPI_WREN_EN
      n_q     <= n_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
`ifdef SPI_WREN_EN
    n_d     = n_q;
`endif
    case (state_q)
      IDLE: if (start_write) begin
`ifdef SPI_WREN_EN
        state_d = WREN;
        sr_d    = {CMD_WREN, frame};
        cnt_d   = 7'd8;
        n_d     = n_bits;
`else
        state_d = SHIFT;
        sr_d    = frame;
        cnt_d   = n_bits;
`endif
        phase_d = 1'b0;
      end
      SHIFT: begin
        phase_d = !phase_q;
        if (phase_q) begin
          sr_d  = sr_q << 1;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
`ifdef SPI_WREN_EN
      // After the last WREN bit the register already holds the write frame MSB at the top.
      WREN: begin
        phase_d = !phase_q;
        if (phase_q) begin
          sr_d  = sr_q << 1;
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            state_d = GAP;
            cnt_d   = n_q;
          end
        end
      end
      // Two cycles with cs high: one full bit period of deselect.
      GAP: begin
        phase_d = !phase_q;
        if (phase_q) state_d = SHIFT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // Pins are registered from next state so sclk and cs come straight off flops and cannot glitch.
`ifdef SPI_WREN_EN
  assign shifting = state_d == SHIFT || state_d == WREN;
`else
  assign shifting = state_d == SHIFT;
`endif
  always_comb begin
    cs_d   = !shifting;
    sclk_d = shifting & phase_d;
    mosi_d = shifting & sr_d[SW-1];
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
  end
  assign cs         = cs_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign write_done = done_q;
  assign busy       = busy_q;
endmodule
